// File: rtl/shift_seq.sv
// Multi-cycle shifter: moves a loaded operand one bit per clock for shamt clocks,
// then raises a single-cycle done strobe. The result register holds until the next accepted start.
module shift_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE, and one cycle with start=1 there
  // accepts din/shamt/op. busy is high while shifting. done pulses for one cycle
  // and result stays valid from then until the next accepted start.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          result_d = din;
          cnt_d    = shamt;
          op_d     = op;
          state_d  = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        // The reserved op code falls into the default and shifts logically right.
        case (op_q)
          2'b00:   result_d = {result_q[WIDTH-2:0], 1'b0};
          2'b10:   result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
          default: result_d = {1'b0, result_q[WIDTH-1:1]};
        endcase
        // SHIFT is entered only with a nonzero count, so this never wraps.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001: Parameter WIDTH, default 32, data path width in bits.
REQ-002: Parameter SHW, default 5, shift-amount width in bits; WIDTH SHALL equal 2**SHW.
REQ-003: clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: start  input  1  request pulse; sampled only in IDLE.
REQ-006: din  input  WIDTH  operand to shift.
REQ-007: shamt  input  SHW  shift distance, 0..WIDTH-1.
REQ-008: op  input  2  00 = logical left, 01 = logical right, 10 = arithmetic right, 11 = reserved.
REQ-009: busy  output  1  high while in SHIFT.
REQ-010: done  output  1  single-cycle completion strobe.
REQ-011: result  output  WIDTH  working register; valid while done is high and until the next accepted start.

Function
REQ-012: The block SHALL be a multi-cycle shifter that moves the operand exactly one bit position per clock, for shamt clocks.
REQ-013: The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014: IDLE with start=1 SHALL load result<=din, counter<=shamt and op_reg<=op, then go to SHIFT if shamt!=0, else to DONE.
REQ-015: IDLE with start=0 SHALL hold all registers.
REQ-016: Each SHIFT edge SHALL apply one step: 00 gives {result[WIDTH-2:0],0}; 01 gives {0,result[WIDTH-1:1]}; 10 gives {result[WIDTH-1],result[WIDTH-1:1]}.
REQ-017: Each SHIFT edge SHALL also decrement the counter.
REQ-018: SHIFT SHALL go to DONE on the edge where the counter equals 1 before decrementing.
REQ-019: DONE SHALL return to IDLE unconditionally after one cycle.
REQ-020: Timing: with start accepted at edge k, done SHALL be high for exactly the cycle after edge k+shamt, including k+0 when shamt=0.
REQ-021: busy SHALL be (state==SHIFT); done SHALL be (state==DONE); both SHALL be registered-state decodes with no combinational path from start.
REQ-022: start SHALL be ignored in SHIFT and DONE; it is neither queued nor an abort.
REQ-023: din, shamt and op changes after acceptance SHALL NOT affect the operation in progress.
REQ-024: op=11 SHALL behave as 01 (logical right).
REQ-025: Bits shifted out SHALL be discarded; there is no carry or overflow output.
REQ-026: result SHALL retain its final value through DONE and IDLE until the next accepted start.
REQ-027: The counter SHALL be SHW bits wide and SHALL never wrap below zero.

Reset
REQ-028: On reset assertion, regardless of clock, the block SHALL set state=IDLE, result=0, counter=0, op_reg=00, busy=0 and done=0.
REQ-029: Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-030: After reset deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-031: Reset, then start with din=32'h0000_0001, shamt=4, op=00 -> busy high 4 cycles; done in cycle after edge k+4; result=32'h0000_0010.
REQ-032: din=32'h8000_0000, shamt=31, op=10 -> result=32'hFFFF_FFFF at done.
REQ-033: Same din with op=01 -> result=32'h0000_0001 at done.
REQ-034: shamt=0, din=32'hA5A5_A5A5 -> busy never high; done in cycle after edge k; result=32'hA5A5_A5A5.
REQ-035: start=1 with din=32'hFFFF_FFFF held every cycle during a shamt=3 op=01 shift of 32'hF000_0000 -> only one operation runs; result=32'h1E00_0000.
REQ-036: A new start accepted in the first IDLE cycle after done -> second operation runs normally.
REQ-037: Reset asserted 2 cycles into a shamt=10 shift -> outputs 0 immediately; no done pulse.
REQ-038: The next start after that reset -> runs normally.
